// File: rtl/bcd_display.sv
// Purpose : sequential binary-to-BCD converter (shift-and-add-3) with active-low 7-segment decode.
// Latency : start accepted at E0, result and one-cycle done after E_WIDTH; back-to-back period WIDTH+1.
// Backpres: none; start is only sampled while idle, so requests arriving during a conversion are dropped.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   start - conversion request, sampled only while idle
//   bin   - binary input, captured on the accepted start edge
//   busy  - high while a conversion is in progress
//   done  - one-cycle pulse; bcd/hex carry the new result from this cycle
//   bcd   - registered result, digit i at [4i+3:4i], i=0 is units
//   hex   - active-low segments, display i at [7i+6:7i], bit0=a .. bit6=g
//
// Optional build macro BCD_DISPLAY_BLANK_EN: leading-zero blanking on displays above
// digit 0. bcd itself is never affected.
module bcd_display #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    // The digit count must be able to hold the largest binary input.
    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_range_check
        $error("bcd_display: DIGITS too small for WIDTH");
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [BW-1:0]    work_q;
    logic [CW-1:0]    cnt_q;
    logic [BW-1:0]    bcd_q;
    logic             done_q;

    logic [BW-1:0]    adj;
    logic [BW-1:0]    work_d;
    logic [WIDTH-1:0] shreg_d;
    logic             unused_adj_msb;

    // Add-3 correction on every working digit >= 5 before the shift.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            else                          adj[4*i +: 4] = work_q[4*i +: 4];
        end
    end

    // Shift {work, shreg} left by one. The top BCD bit falls off, which is
    // always zero because the digit count covers the input range.
    assign work_d         = {adj[BW-2:0], shreg_q[WIDTH-1]};
    assign shreg_d        = shreg_q << 1;
    assign unused_adj_msb = adj[BW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shreg_q <= bin;
                        work_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    shreg_q <= shreg_d;
                    work_q  <= work_d;
                    cnt_q   <= cnt_q + 1'b1;
                    // Last iteration: publish the shifted value directly so the
                    // result lands on the same edge that leaves CONV.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        bcd_q   <= work_d;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == CONV);
    assign done = done_q;
    assign bcd  = bcd_q;

`ifdef BCD_DISPLAY_BLANK_EN
    logic lz_run;

    // Walk from the most significant digit down; a digit is blanked while it
    // and everything above it are zero. Digit 0 always shows.
    always_comb begin
        hex    = '1;
        lz_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz_run = lz_run & (bcd_q[4*i +: 4] == 4'd0);
            if ((i > 0) && lz_run) hex[7*i +: 7] = 7'b1111111;
            else                   hex[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
        end
    end
`else
    always_comb begin
        hex = '1;
        for (int i = 0; i < DIGITS; i++) hex[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
    end
`endif

endmodule

// File: tb/tb_bcd_display.sv
// Purpose : directed self-checking bench for bcd_display (WIDTH=8, DIGITS=3).
// Latency : inputs driven and outputs sampled on the falling edge, away from the active edge.
// Backpres: n/a.
module tb_bcd_display;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S5 = 7'b0010010, S7 = 7'b1111000, S8 = 7'b0000000;
    localparam logic [6:0] SB = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic [20:0] hex;

    int checks = 0;
    int errors = 0;

    bcd_display #(.WIDTH(8), .DIGITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .hex   (hex)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, then wait (bounded) for done, counting busy cycles.
    // Returns with the bench parked on the negedge of the done cycle.
    task automatic run_conv(input logic [7:0] v, output int nb);
        int guard;
        @(negedge clk); start = 1'b1; bin = v;
        @(negedge clk); start = 1'b0; bin = ~v;
        nb = 0; guard = 0;
        while (done !== 1'b1 && guard < 40) begin
            if (busy === 1'b1) nb++;
            @(negedge clk);
            guard++;
        end
    endtask

    initial begin
        int nb;
        int guard;
        int done_cnt;
        logic held_ok;
        logic [11:0] bcd_at_done;

        rst_n = 1'b0; start = 1'b0; bin = 8'd0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_bcd", bcd, 12'h000);
`ifdef BCD_DISPLAY_BLANK_EN
        chk("reset_hex", hex, {SB, SB, S0});
`else
        chk("reset_hex", hex, {S0, S0, S0});
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 255: full-range conversion, exactly 8 busy cycles
        run_conv(8'd255, nb);
        chk("c255_busy_cycles", nb, 8);
        chk("c255_done", done, 1);
        chk("c255_busy_off", busy, 0);
        chk("c255_bcd", bcd, 12'h255);
        chk("c255_hex", hex, {S2, S5, S5});
        @(negedge clk);
        chk("c255_done_one_cycle", done, 0);

        // asynchronous reset mid-cycle clears the held result at once
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_bcd", bcd, 12'h000);
`ifdef BCD_DISPLAY_BLANK_EN
        chk("arst_hex", hex, {SB, SB, S0});
`else
        chk("arst_hex", hex, {S0, S0, S0});
`endif
        @(negedge clk); rst_n = 1'b1;

        // back-to-back: 100 then 9, start held high through the done cycle
        @(negedge clk); start = 1'b1; bin = 8'd100;
        @(negedge clk); bin = 8'd9;
        nb = 0; guard = 0;
        while (done !== 1'b1 && guard < 40) begin
            if (busy === 1'b1) nb++;
            @(negedge clk);
            guard++;
        end
        chk("b2b1_busy_cycles", nb, 8);
        chk("b2b1_done", done, 1);
        chk("b2b1_bcd", bcd, 12'h100);
        @(negedge clk); start = 1'b0;
        chk("b2b2_accepted_in_done_cycle", busy, 1);
        nb = 0; guard = 0; held_ok = 1'b1;
        while (done !== 1'b1 && guard < 40) begin
            if (busy === 1'b1) nb++;
            if (bcd !== 12'h100) held_ok = 1'b0;
            @(negedge clk);
            guard++;
        end
        chk("b2b2_bcd_held", held_ok, 1);
        chk("b2b2_busy_cycles", nb, 8);
        chk("b2b2_done", done, 1);
        chk("b2b2_bcd", bcd, 12'h009);

        // start during CONV is ignored
        @(negedge clk); start = 1'b1; bin = 8'd37;
        @(negedge clk); start = 1'b0; bin = 8'd0;
        @(negedge clk);
        @(negedge clk); start = 1'b1; bin = 8'd200;
        @(negedge clk); start = 1'b0;
        done_cnt = 0; bcd_at_done = 12'hfff;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1) begin
                done_cnt++;
                bcd_at_done = bcd;
            end
            @(negedge clk);
        end
        chk("ign_done_count", done_cnt, 1);
        chk("ign_bcd", bcd_at_done, 12'h037);
        chk("ign_idle_after", busy, 0);

        // reset during conversion: no done, partial result discarded
        @(negedge clk); start = 1'b1; bin = 8'd199;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rconv_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rconv_busy", busy, 0);
        chk("rconv_bcd", bcd, 12'h000);
        @(negedge clk); rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        chk("rconv_no_done", done_cnt, 0);
        chk("rconv_bcd_after", bcd, 12'h000);
        run_conv(8'd42, nb);
        chk("c42_busy_cycles", nb, 8);
        chk("c42_bcd", bcd, 12'h042);

        // display patterns, with and without leading-zero blanking
        run_conv(8'd7, nb);
        chk("c7_bcd", bcd, 12'h007);
`ifdef BCD_DISPLAY_BLANK_EN
        chk("c7_hex", hex, {SB, SB, S7});
`else
        chk("c7_hex", hex, {S0, S0, S7});
`endif
        run_conv(8'd58, nb);
        chk("c58_bcd", bcd, 12'h058);
`ifdef BCD_DISPLAY_BLANK_EN
        chk("c58_hex", hex, {SB, S5, S8});
`else
        chk("c58_hex", hex, {S0, S5, S8});
`endif
        run_conv(8'd105, nb);
        chk("c105_bcd", bcd, 12'h105);
        chk("c105_hex", hex, {S1, S0, S5});
        run_conv(8'd0, nb);
        chk("c0_busy_cycles", nb, 8);
        chk("c0_bcd", bcd, 12'h000);
`ifdef BCD_DISPLAY_BLANK_EN
        chk("c0_hex", hex, {SB, SB, S0});
`else
        chk("c0_hex", hex, {S0, S0, S0});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
